// File: rtl/game_pkg.sv
// Constants and types shared by the brick-breaker game blocks (ball, paddle, bricks).
package game_pkg;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int PADDLE_Y = 440;
  localparam int PADDLE_W = 80;

  localparam logic [23:0] BLACK = '0;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  typedef enum logic [1:0] {
    SERVE,
    MOVE,
    LOST,
    GAME_OVER
  } ball_state_t;
endpackage

// File: rtl/ball_motion_if.sv
// Pixel-scan, paddle and serve inputs to the ball block, and its render/status outputs.
interface ball_motion_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active_pixels;
  logic [9:0]  paddle_x;
  logic        launch;
  logic [23:0] ball_color;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic        ball_lost;
  logic [1:0]  lives;
  logic        game_over;

  modport master (
    output x, y, active_pixels, paddle_x, launch,
    input  ball_color, ball_x, ball_y, ball_lost, lives, game_over
  );

  modport slave (
    input  x, y, active_pixels, paddle_x, launch,
    output ball_color, ball_x, ball_y, ball_lost, lives, game_over
  );
endinterface

// File: rtl/ball_motion_frame_tick_gen.sv
// One-clock pulse per frame, raised when the scan first reaches (0, V_RES).
module frame_tick_gen #(
  parameter int V_RES = game_pkg::V_RES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       tick
);
  logic at_frame;
  logic at_frame_q;

  // Each pixel is held for two clocks, so edge-detect to get a single pulse.
  assign at_frame = (y == 10'(V_RES)) && (x == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      at_frame_q <= 1'b0;
      tick       <= 1'b0;
    end else begin
      at_frame_q <= at_frame;
      tick       <= at_frame && !at_frame_q;
    end
  end
endmodule

// File: rtl/ball_motion.sv
// Ball position/velocity, serve, bounces, miss and lives tracking, plus ball pixel render.
module ball_motion #(
  parameter int          H_RES          = game_pkg::H_RES,
  parameter int          V_RES          = game_pkg::V_RES,
  parameter int          BALL_SIZE      = 8,
  parameter int          SPEED          = 2,
  parameter int          PADDLE_Y       = game_pkg::PADDLE_Y,
  parameter int          PADDLE_W       = game_pkg::PADDLE_W,
  parameter int          RESPAWN_FRAMES = 60,
  parameter int          LIVES_INIT     = 3,
  parameter logic [23:0] BALL_RGB       = game_pkg::WHITE
) (
  input logic          clk,
  input logic          rst,
  ball_motion_if.slave bus
);
  import game_pkg::*;

  localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);

  localparam logic signed [10:0] ZERO      = 11'sd0;
  localparam logic signed [10:0] SIZE      = 11'(BALL_SIZE);
  localparam logic signed [10:0] STEP      = 11'(SPEED);
  localparam logic signed [10:0] X_MAX     = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] Y_MISS    = 11'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] PAD_TOP   = 11'(PADDLE_Y);
  localparam logic signed [10:0] PAD_W     = 11'(PADDLE_W);
  localparam logic signed [10:0] SERVE_Y   = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic signed [10:0] SERVE_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RESPAWN_FRAMES - 1);

  ball_state_t       state;
  logic signed [10:0] bx, by;
  logic signed [10:0] nx, ny;
  logic signed [10:0] pad, serve_x, px, py;
  logic              dx_pos, dy_pos;
  logic              hit, drawn;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        lives_q;
  logic              lost_q, over_q;
  logic              tick;

  frame_tick_gen #(.V_RES(V_RES)) u_frame_tick (
    .clk  (clk),
    .rst  (rst),
    .x    (bus.x),
    .y    (bus.y),
    .tick (tick)
  );

  assign pad     = signed'({1'b0, bus.paddle_x});
  assign serve_x = pad + SERVE_OFS;

  always_comb begin
    nx  = dx_pos ? bx + STEP : bx - STEP;
    ny  = dy_pos ? by + STEP : by - STEP;
    hit = dy_pos && (by + SIZE <= PAD_TOP) && (ny + SIZE >= PAD_TOP) &&
          (bx + SIZE > pad) && (bx < pad + PAD_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SERVE;
      bx      <= serve_x;
      by      <= SERVE_Y;
      dx_pos  <= 1'b1;
      dy_pos  <= 1'b0;
      cnt     <= '0;
      lives_q <= 2'(LIVES_INIT);
      lost_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      if (tick) begin
        unique case (state)
          SERVE: begin
            bx <= serve_x;
            by <= SERVE_Y;
            if (bus.launch) begin
              dx_pos <= 1'b1;
              dy_pos <= 1'b0;
              state  <= MOVE;
            end
          end
          MOVE: begin
            // Axes resolve independently so a corner reflects both in one frame.
            if (nx <= ZERO) begin
              bx     <= ZERO;
              dx_pos <= 1'b1;
            end else if (nx >= X_MAX) begin
              bx     <= X_MAX;
              dx_pos <= 1'b0;
            end else begin
              bx <= nx;
            end
            if (ny <= ZERO) begin
              by     <= ZERO;
              dy_pos <= 1'b1;
            end else if (hit) begin
              by     <= SERVE_Y;
              dy_pos <= 1'b0;
            end else if (ny >= Y_MISS) begin
              by      <= Y_MISS;
              lives_q <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
              lost_q  <= 1'b1;
              cnt     <= '0;
              state   <= LOST;
            end else begin
              by <= ny;
            end
          end
          LOST: begin
            if (cnt == CNT_LAST) begin
              if (lives_q == 2'd0) begin
                state  <= GAME_OVER;
                over_q <= 1'b1;
              end else begin
                // Place the ball on entry so it never flashes at the miss row.
                state <= SERVE;
                bx    <= serve_x;
                by    <= SERVE_Y;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAME_OVER: over_q <= 1'b1;
          default:   state  <= SERVE;
        endcase
      end
    end
  end

  assign px    = signed'({1'b0, bus.x});
  assign py    = signed'({1'b0, bus.y});
  assign drawn = (state == SERVE) || (state == MOVE);

  assign bus.ball_color = (bus.active_pixels && drawn &&
                           px >= bx && px < bx + SIZE &&
                           py >= by && py < by + SIZE) ? BALL_RGB : BLACK;
  assign bus.ball_x     = bx[9:0];
  assign bus.ball_y     = by[9:0];
  assign bus.ball_lost  = lost_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = over_q;
endmodule
